// File: rtl/msg_pkg.sv
// msg_pkg: shared FSM states, terminator and default message text
// for the command-selected message printer.
package msg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] MSG_TERM = 8'h00;

  // msg0 "Hi\n", msg1 "Bye\n", msg2 empty,
  // msg3 "A".."P" with no terminator.
  function automatic logic [7:0] def_char(
    input int unsigned k,
    input int unsigned j
  );
    logic [7:0] c;
    c = MSG_TERM;
    case (k)
      0: begin
        case (j)
          0: c = 8'h48;
          1: c = 8'h69;
          2: c = 8'h0A;
          default: c = MSG_TERM;
        endcase
      end
      1: begin
        case (j)
          0: c = 8'h42;
          1: c = 8'h79;
          2: c = 8'h65;
          3: c = 8'h0A;
          default: c = MSG_TERM;
        endcase
      end
      3: begin
        if (j < 16) c = 8'h41 + 8'(j);
      end
      default: c = MSG_TERM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/msg_select_printer_rom.sv
// msg_rom: synchronous-read message store, NUM_MSGS x MAX_LEN chars,
// contents taken from msg_pkg; out-of-range reads return 0.
import msg_pkg::*;

module msg_rom #(
  parameter int DATA_W   = 8,
  parameter int NUM_MSGS = 4,
  parameter int MAX_LEN  = 16,
  parameter int SEL_W    = 2,
  parameter int IDX_W    = 5
) (
  input  logic              clk,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;

  // Combinational lookup of the addressed character.
  always_comb begin
    w_data = '0;
    if ((int'(i_sel) < NUM_MSGS) &&
        (int'(i_idx) < MAX_LEN)) begin
      w_data = DATA_W'(def_char(32'(i_sel), 32'(i_idx)));
    end
  end

  // Registered read port: data appears the cycle after the address.
  always_ff @(posedge clk) begin
    r_data <= w_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/msg_select_printer.sv
// msg_select_printer: rx command byte selects a stored message, streamed
// to tx under tx_busy. Define MSG_BITREV_EN to send chars bit-reversed.
import msg_pkg::*;

module msg_select_printer #(
  parameter int          DATA_W   = 8,
  parameter int          NUM_MSGS = 4,
  parameter int          MAX_LEN  = 16,
  parameter int unsigned SEL_BASE = 'h30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              new_rx_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              new_tx_data,
  output logic              busy,
  output logic              msg_done
);

  localparam int SEL_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int IDX_W = $clog2(MAX_LEN + 1);

  localparam logic [DATA_W:0] CMD_LO =
    (DATA_W+1)'(SEL_BASE);
  localparam logic [DATA_W:0] CMD_HI =
    (DATA_W+1)'(SEL_BASE + NUM_MSGS);
  localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(MAX_LEN);
  localparam logic [DATA_W-1:0] TERM = DATA_W'(MSG_TERM);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [SEL_W-1:0]  r_pend_sel;
  logic [SEL_W-1:0]  w_pend_sel_nxt;
  logic              r_pend_v;
  logic              w_pend_v_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_new_tx;
  logic              w_new_tx_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_tx_data_nxt;
  logic [DATA_W-1:0] w_char;
  logic [DATA_W-1:0] w_tx_char;
  logic [DATA_W:0]   w_rx_ext;
  logic              w_cmd_v;
  logic [SEL_W-1:0]  w_cmd_sel;
  logic              w_at_end;

  assign w_rx_ext  = {1'b0, rx_data};
  assign w_cmd_v   = new_rx_data &&
                     (w_rx_ext >= CMD_LO) &&
                     (w_rx_ext < CMD_HI);
  assign w_cmd_sel = SEL_W'(w_rx_ext - CMD_LO);

  msg_rom #(
    .DATA_W   (DATA_W),
    .NUM_MSGS (NUM_MSGS),
    .MAX_LEN  (MAX_LEN),
    .SEL_W    (SEL_W),
    .IDX_W    (IDX_W)
  ) u_rom (
    .clk    (clk),
    .i_sel  (r_sel),
    .i_idx  (r_idx),
    .o_data (w_char)
  );

`ifdef MSG_BITREV_EN
  // Mirror the character: bit i goes to bit DATA_W-1-i.
  always_comb begin
    w_tx_char = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_tx_char[i] = w_char[DATA_W-1-i];
    end
  end
`else
  assign w_tx_char = w_char;
`endif

  // Stop on terminator (raw char) or once MAX_LEN chars have gone out.
  assign w_at_end = (w_char == TERM) || (r_idx == IDX_LIM);

  // Next-state and datapath updates; defaults hold everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_idx_nxt      = r_idx;
    w_pend_v_nxt   = r_pend_v;
    w_pend_sel_nxt = r_pend_sel;
    w_busy_nxt     = r_busy;
    w_new_tx_nxt   = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    if (w_cmd_v && r_busy) begin
      w_pend_v_nxt   = 1'b1;
      w_pend_sel_nxt = w_cmd_sel;
    end
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_v) begin
          w_sel_nxt   = w_cmd_sel;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_at_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_tx_data_nxt = w_tx_char;
          if (!tx_busy) begin
            w_new_tx_nxt = 1'b1;
            w_idx_nxt    = r_idx + IDX_W'(1);
            w_state_nxt  = S_GAP;
          end
        end
      end
      S_GAP: begin
        w_state_nxt = S_FETCH;
      end
      S_DONE: begin
        if (w_cmd_v || r_pend_v) begin
          w_sel_nxt    = w_cmd_v ? w_cmd_sel : r_pend_sel;
          w_pend_v_nxt = 1'b0;
          w_idx_nxt    = '0;
          w_state_nxt  = S_FETCH;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Selection, index, pending command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= '0;
      r_idx      <= '0;
      r_pend_v   <= 1'b0;
      r_pend_sel <= '0;
      r_busy     <= 1'b0;
      r_new_tx   <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_sel      <= w_sel_nxt;
      r_idx      <= w_idx_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_sel <= w_pend_sel_nxt;
      r_busy     <= w_busy_nxt;
      r_new_tx   <= w_new_tx_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;
  assign busy        = r_busy;
  assign msg_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_msg_select_printer.sv
// tb_msg_select_printer: table vectors, directed corner sequences and
// randomized commands against a string-level message model.
module tb_msg_select_printer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       busy;
  logic       msg_done;

  always #5 clk = ~clk;

  msg_select_printer #(
    .DATA_W   (8),
    .NUM_MSGS (4),
    .MAX_LEN  (16),
    .SEL_BASE ('h30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .busy        (busy),
    .msg_done    (msg_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Monitor: logs every strobe and done pulse with its cycle number.
  logic [7:0] mon_q[$];
  int         mon_qc[$];
  int         mon_dc[$];
  int         cyc = 0;
  int         viol = 0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (new_tx_data === 1'b1) begin
      mon_q.push_back(tx_data);
      mon_qc.push_back(cyc);
      if (prev_busy) viol = viol + 1;
    end
    if (msg_done === 1'b1) mon_dc.push_back(cyc);
    prev_busy = tx_busy;
  end

  string MSGS[4];
  int    cmd_cyc;
  bit    rnd_busy = 1'b0;

  function automatic logic [7:0] exp_char(input logic [7:0] c);
    logic [7:0] r;
    r = c;
`ifdef MSG_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = c[7-i];
`endif
    return r;
  endfunction

  function automatic void model_msg(
    input int k, inout logic [7:0] q[$]
  );
    string s;
    s = MSGS[k];
    for (int i = 0; i < s.len() && i < 16; i++)
      q.push_back(exp_char(s[i]));
  endfunction

  task automatic check(
    input string n, input logic [31:0] act, input logic [31:0] req
  );
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_busy) tx_busy = ($urandom_range(0, 9) < 3);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data = c;
    new_rx_data = 1'b1;
    cmd_cyc = cyc + 1;
    step();
    new_rx_data = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(k >= budget), 0);
    repeat (3) step();
  endtask

  task automatic check_stream(
    input string n, input int bs, input logic [7:0] e[$]
  );
    int got;
    got = mon_q.size() - bs;
    check({n, "_count"}, got, e.size());
    for (int i = 0; i < got && i < e.size(); i++)
      check({n, "_char"}, mon_q[bs+i], e[i]);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         n_str;
    logic [7:0] first;
    int         n_done;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] e[$];
    int bs;
    int bd;
    int last;
    int a;
    logic [7:0] b;

    MSGS[0] = "Hi\n";
    MSGS[1] = "Bye\n";
    MSGS[2] = "";
    MSGS[3] = "ABCDEFGHIJKLMNOP";

    vecs[0] = '{8'h30, 3, 8'h48, 1, 3};
    vecs[1] = '{8'h32, 0, 8'h00, 1, 3};
    vecs[2] = '{8'h33, 16, 8'h41, 1, 3};
    vecs[3] = '{8'h78, 0, 8'h00, 0, -1};
    vecs[4] = '{8'h2F, 0, 8'h00, 0, -1};
    vecs[5] = '{8'h34, 0, 8'h00, 0, -1};
    vecs[6] = '{8'h31, 4, 8'h42, 1, 3};

    rst = 1'b1;
    rx_data = 8'h00;
    new_rx_data = 1'b0;
    tx_busy = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    check("rst_tx_data", tx_data, 0);
    check("rst_new_tx", new_tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_msg_done", msg_done, 0);
    step();

    // Table-driven single commands with tx_busy low.
    for (int v = 0; v < 7; v++) begin
      bs = mon_q.size();
      bd = mon_dc.size();
      send_cmd(vecs[v].cmd);
      wait_idle(200);
      check("vec_strobes", mon_q.size() - bs, vecs[v].n_str);
      check("vec_dones", mon_dc.size() - bd, vecs[v].n_done);
      check("vec_busy_end", busy, 0);
      if (vecs[v].n_str > 0) begin
        check("vec_first", mon_q[bs], exp_char(vecs[v].first));
        check("vec_lat_tx", mon_qc[bs] - cmd_cyc, vecs[v].lat);
      end else if (vecs[v].n_done > 0) begin
        check("vec_lat_done", mon_dc[bd] - cmd_cyc, vecs[v].lat);
      end
      if (vecs[v].n_done > 0) begin
        e = {};
        model_msg(int'(vecs[v].cmd) - 'h30, e);
        check_stream("vec_stream", bs, e);
      end
    end

    // Long tx_busy stall on the first char of msg1.
    bs = mon_q.size();
    tx_busy = 1'b1;
    send_cmd(8'h31);
    repeat (2) step();
    for (int i = 0; i < 50; i++) begin
      check("stall_no_strobe", new_tx_data, 0);
      check("stall_tx_data", tx_data, exp_char(8'h42));
      step();
    end
    check("stall_count", mon_q.size() - bs, 0);
    tx_busy = 1'b0;
    step();
    check("release_strobe", new_tx_data, 1);
    check("release_data", tx_data, exp_char(8'h42));
    wait_idle(200);
    e = {};
    model_msg(1, e);
    check_stream("stall_stream", bs, e);

    // Pending command: '0' overwritten by '3' while msg1 prints.
    bs = mon_q.size();
    bd = mon_dc.size();
    send_cmd(8'h31);
    repeat (4) step();
    send_cmd(8'h30);
    repeat (2) step();
    send_cmd(8'h33);
    wait_idle(400);
    e = {};
    model_msg(1, e);
    model_msg(3, e);
    check_stream("pend_stream", bs, e);
    check("pend_dones", mon_dc.size() - bd, 2);

    // Reset in the middle of msg3.
    send_cmd(8'h33);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_new_tx", new_tx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", msg_done, 0);
    bs = mon_q.size();
    repeat (60) step();
    check("mid_rst_quiet", mon_q.size() - bs, 0);
    check("mid_rst_idle", busy, 0);

    // Randomized commands and follow-ups under random tx_busy.
    rnd_busy = 1'b1;
    for (int it = 0; it < 30; it++) begin
      bs = mon_q.size();
      bd = mon_dc.size();
      a = $urandom_range(0, 3);
      last = -1;
      send_cmd(8'(8'h30 + a));
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1)
            b = 8'(8'h30 + $urandom_range(0, 3));
          else
            b = 8'($urandom_range(0, 255));
          if (b >= 8'h30 && b < 8'h34) last = int'(b) - 'h30;
          send_cmd(b);
        end else begin
          step();
        end
      end
      wait_idle(2000);
      e = {};
      model_msg(a, e);
      if (last >= 0) model_msg(last, e);
      check_stream("rnd_stream", bs, e);
      check("rnd_dones", mon_dc.size() - bd, (last >= 0) ? 2 : 1);
    end
    rnd_busy = 1'b0;
    tx_busy = 1'b0;
    step();
    check("busy_rule_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
